// File: rtl/riscv_insn_types_pkg.sv
// Shared RV32 instruction types: raw instruction word, decoded field record,
// format classification and per-format field extraction, plus the decode
// stage record carried through the skid buffer.
package riscv_insn_types;

  typedef logic [31:0] insn_t;

  typedef enum logic [2:0] {
    ITYPE_NONE = 3'd0,
    ITYPE_R    = 3'd1,
    ITYPE_I    = 3'd2,
    ITYPE_S    = 3'd3,
    ITYPE_B    = 3'd4,
    ITYPE_U    = 3'd5,
    ITYPE_J    = 3'd6
  } itype_e;

  // imm holds the raw immediate bits of the format, right-aligned, unscaled
  // and not sign-extended; consumers rebuild the architectural value.
  typedef struct packed {
    itype_e      itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm;
  } insn_info_t;

  // Widest instruction address the decode record can carry.
  localparam int unsigned DECODE_PC_W = 32;

  typedef struct packed {
    insn_info_t             info;
    logic [DECODE_PC_W-1:0] pc;
    logic                   illegal;
  } decode_rec_t;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OP_IMM = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  function automatic logic is_r_format(input logic [6:0] op);
    return (op == OP_OP);
  endfunction

  function automatic logic is_i_format(input logic [6:0] op);
    return (op == OP_OP_IMM) || (op == OP_LOAD) || (op == OP_JALR) || (op == OP_SYSTEM);
  endfunction

  function automatic logic is_s_format(input logic [6:0] op);
    return (op == OP_STORE);
  endfunction

  function automatic logic is_b_format(input logic [6:0] op);
    return (op == OP_BRANCH);
  endfunction

  function automatic logic is_u_format(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  function automatic logic is_j_format(input logic [6:0] op);
    return (op == OP_JAL);
  endfunction

  function automatic insn_info_t r_extract_fields(input insn_t insn);
    insn_info_t f;
    f        = '0;
    f.itype  = ITYPE_R;
    f.rd     = insn[11:7];
    f.rs1    = insn[19:15];
    f.rs2    = insn[24:20];
    f.funct3 = insn[14:12];
    f.funct7 = insn[31:25];
    return f;
  endfunction

  function automatic insn_info_t i_extract_fields(input insn_t insn);
    insn_info_t f;
    f        = '0;
    f.itype  = ITYPE_I;
    f.rd     = insn[11:7];
    f.rs1    = insn[19:15];
    f.funct3 = insn[14:12];
    f.imm    = {8'd0, insn[31:20]};
    return f;
  endfunction

  function automatic insn_info_t s_extract_fields(input insn_t insn);
    insn_info_t f;
    f        = '0;
    f.itype  = ITYPE_S;
    f.rs1    = insn[19:15];
    f.rs2    = insn[24:20];
    f.funct3 = insn[14:12];
    f.imm    = {8'd0, insn[31:25], insn[11:7]};
    return f;
  endfunction

  // Branch offset bits imm[12:1]; bit 0 is implicitly zero.
  function automatic insn_info_t b_extract_fields(input insn_t insn);
    insn_info_t f;
    f        = '0;
    f.itype  = ITYPE_B;
    f.rs1    = insn[19:15];
    f.rs2    = insn[24:20];
    f.funct3 = insn[14:12];
    f.imm    = {8'd0, insn[31], insn[7], insn[30:25], insn[11:8]};
    return f;
  endfunction

  function automatic insn_info_t u_extract_fields(input insn_t insn);
    insn_info_t f;
    f       = '0;
    f.itype = ITYPE_U;
    f.rd    = insn[11:7];
    f.imm   = insn[31:12];
    return f;
  endfunction

  // Jump offset bits imm[20:1]; bit 0 is implicitly zero.
  function automatic insn_info_t j_extract_fields(input insn_t insn);
    insn_info_t f;
    f       = '0;
    f.itype = ITYPE_J;
    f.rd    = insn[11:7];
    f.imm   = {insn[31], insn[19:12], insn[20], insn[30:21]};
    return f;
  endfunction

endpackage

// File: rtl/riscv_skid_buffer.sv
// Two-entry (main + skid) valid/ready buffer. in_ready is a flop so the
// upstream never sees a combinational path from out_ready. flush clears both
// entries and wins over any transfer in the same cycle.
module riscv_skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  T     main_q, main_d;
  T     skid_q, skid_d;

  logic in_xfer_s;
  logic out_xfer_s;

  assign in_xfer_s  = in_valid && in_ready_q;
  assign out_xfer_s = main_valid_q && out_ready;

  // Next-state for the two entries: drain from skid first to keep order.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer_s) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer_s) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (in_xfer_s) begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (in_xfer_s) begin
      main_d       = in_data;
      main_valid_d = 1'b1;
    end else begin
      main_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Entry state and registered in_ready; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32 decode stage: combinational format decode feeding a registered
// two-entry skid buffer. Optional delivery counters are built only when
// RISCV_DECODE_STATS_EN is defined; otherwise the stat ports read zero.
module riscv_decode_stage
  import riscv_insn_types::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  insn_t               in_insn,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output insn_info_t          out_info,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_illegal,
  output logic [31:0]         stat_decoded,
  output logic [31:0]         stat_illegal
);

  decode_rec_t dec_rec_s;
  decode_rec_t out_rec_s;
  logic [6:0]  opcode_s;

  assign opcode_s = in_insn[6:0];

  // Classify in R, I, S, B, U, J priority order; no match leaves info zero.
  always_comb begin
    dec_rec_s                   = '0;
    dec_rec_s.pc[PC_WIDTH-1:0]  = in_pc;
    if (in_insn[1:0] != 2'b11) begin
      dec_rec_s.illegal = 1'b1;
    end else if (is_r_format(opcode_s)) begin
      dec_rec_s.info = r_extract_fields(in_insn);
    end else if (is_i_format(opcode_s)) begin
      dec_rec_s.info = i_extract_fields(in_insn);
    end else if (is_s_format(opcode_s)) begin
      dec_rec_s.info = s_extract_fields(in_insn);
    end else if (is_b_format(opcode_s)) begin
      dec_rec_s.info = b_extract_fields(in_insn);
    end else if (is_u_format(opcode_s)) begin
      dec_rec_s.info = u_extract_fields(in_insn);
    end else if (is_j_format(opcode_s)) begin
      dec_rec_s.info = j_extract_fields(in_insn);
    end else begin
      dec_rec_s.illegal = 1'b1;
    end
  end

  riscv_skid_buffer #(
    .T (decode_rec_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_rec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_rec_s)
  );

  assign out_info    = out_rec_s.info;
  assign out_pc      = out_rec_s.pc[PC_WIDTH-1:0];
  assign out_illegal = out_rec_s.illegal;

`ifdef RISCV_DECODE_STATS_EN
  logic [31:0] stat_decoded_q, stat_decoded_d;
  logic [31:0] stat_illegal_q, stat_illegal_d;
  logic        out_xfer_s;

  assign out_xfer_s = out_valid && out_ready;

  // Count delivered records; both counters wrap naturally at 2^32.
  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_illegal_d = stat_illegal_q;
    if (out_xfer_s) begin
      stat_decoded_d = stat_decoded_q + 32'd1;
      if (out_illegal) begin
        stat_illegal_d = stat_illegal_q + 32'd1;
      end else begin
        stat_illegal_d = stat_illegal_q;
      end
    end else begin
      stat_decoded_d = stat_decoded_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded_q <= 32'd0;
      stat_illegal_q <= 32'd0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`else
  assign stat_decoded = 32'd0;
  assign stat_illegal = 32'd0;
`endif

endmodule

// File: doc/riscv_decode_stage.md
RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, the width of the instruction address carried alongside each instruction.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the fetch side offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage accepts the offered instruction.
REQ-007 The block SHALL have port in_insn, input, insn_t: the raw 32-bit instruction.
REQ-008 The block SHALL have port in_pc, input, PC_WIDTH bits: the instruction address.
REQ-009 The block SHALL have port out_valid, output, 1 bit: decoded record available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the record.
REQ-011 The block SHALL have port out_info, output, insn_info_t: the decoded fields.
REQ-012 The block SHALL have port out_pc, output, PC_WIDTH bits: the address of the out_info instruction.
REQ-013 The block SHALL have port out_illegal, output, 1 bit: the opcode matches no supported format.
REQ-014 The block SHALL have port stat_decoded, output, 32 bits: the count of records delivered.
REQ-015 The block SHALL have port stat_illegal, output, 32 bits: the count of illegal records delivered.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Decode SHALL classify opcode insn[6:0] against R, I, S, B, U, J in that priority order and fill out_info with the matching riscv_insn_types *_extract_fields result.
REQ-018 An instruction with no format match, or with insn[1:0] != 2'b11, SHALL produce out_illegal=1 with out_info all-zero.
REQ-019 Decode SHALL be done before registering, so out_* are registered outputs and latency is 1 cycle from input transfer to out_valid.
REQ-020 Storage SHALL be two entries: main register (drives out_*) and skid register.
REQ-021 in_ready SHALL equal the inverse of skid-valid and SHALL be a register output with no combinational path from out_ready.
REQ-022 When an input transfer occurs while main is valid and is not draining this cycle, the record SHALL go into skid.
REQ-023 When main drains (output transfer) and skid is valid, main SHALL load from skid and skid SHALL clear.
REQ-024 When main drains and skid is empty, main SHALL load from the input if an input transfer occurs; otherwise out_valid SHALL fall.
REQ-025 When main is empty, an input transfer SHALL load main directly.
REQ-026 Instruction order SHALL be preserved under all back-pressure patterns; no record SHALL be dropped or duplicated.
REQ-027 flush SHALL take priority over all other events: both valid bits clear next cycle, and any input transfer in the flush cycle is discarded.
REQ-028 flush SHALL force in_ready=1 on the next cycle.

Reset
REQ-029 While rst is asserted, out_valid and skid-valid SHALL be 0, in_ready SHALL be 1, stat counters SHALL be 0, and out_info/out_pc/out_illegal SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all held records immediately, without waiting for a clock edge.

Configuration
REQ-031 With macro RISCV_DECODE_STATS_EN defined, stat_decoded SHALL increment on every output transfer and stat_illegal SHALL increment on output transfers with out_illegal=1.
REQ-032 Both stat counters SHALL wrap modulo 2^32.
REQ-033 Without RISCV_DECODE_STATS_EN, the stat ports SHALL still exist, be tied to 0, and contain no counter flops.

Structure
REQ-034 insn_t, insn_info_t, the itype enumeration and the format classifier/extract functions SHALL come from the shared riscv_insn_types package.
REQ-035 The decode record type (info + pc + illegal) SHALL be added to that package as decode_rec_t.
REQ-036 One sub-module, riscv_skid_buffer, SHALL be parameterised on the record type and hold the main/skid registers and handshake logic.
REQ-037 Decode SHALL be combinational logic in riscv_decode_stage.

Verification
REQ-038 in_insn=0x003100B3, out_ready=1 -> one cycle later: out_valid=1, itype=R, rd=1, rs1=2, rs2=3, funct3=0, funct7=0.
REQ-039 in_insn=0xFFF00293 -> itype=I, rd=5, rs1=0, imm=20'h00FFF, out_illegal=0.
REQ-040 in_insn=0x00000000 -> out_illegal=1, out_info=0; with RISCV_DECODE_STATS_EN, stat_illegal=1 after the transfer.
REQ-041 Hold out_ready=0 and offer three instructions back-to-back -> first two accepted, in_ready=0 from the cycle after the second; raising out_ready delivers all three in order.
REQ-042 flush with both entries full -> out_valid=0 and in_ready=1 next cycle, and no flushed record appears later.
REQ-043 Assert rst asynchronously between clock edges with out_valid=1 -> out_valid=0 immediately and stats=0.
